pinmux_pad_attr_ctrl: RTL

- Runtime-programmable pad attribute controller. Replaces per-instance parameter-only pad type selection with a register bank holding one attribute word per pad.
- Sits between the pinmux register interface and the pad wrappers.
- Each attribute change is applied through a glitch-safe sequence: gate the pad, settle, apply, settle, release.
- Per-pad sticky lock bits freeze attributes until reset.

---
 rtl/pinmux_pad_attr_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pinmux_pad_attr_ctrl.sv
// Runtime pad attribute bank with per-pad sticky locks.
// Attribute changes run gate -> settle -> apply -> settle -> release.
module pinmux_pad_attr_ctrl #(
    parameter int                   NumPads        = 8,
    parameter int                   AttrWidth      = 8,
    parameter logic [AttrWidth-1:0] PadTypeDefault = AttrWidth'(1),
    parameter int                   SettleCycles   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    input  logic                           we_i,
    input  logic [$clog2(NumPads+1)-1:0]   addr_i,
    input  logic [AttrWidth-1:0]           wdata_i,
    output logic                           rvalid_o,
    output logic [AttrWidth-1:0]           rdata_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [NumPads*AttrWidth-1:0]   attr_o,
    output logic [NumPads-1:0]             pad_gate_o
);

    localparam int AW = $clog2(NumPads + 1);
    localparam int IW = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam int CW = $clog2(SettleCycles + 1);
    localparam logic [AW-1:0] LockAddr = AW'(NumPads);
    localparam logic [CW-1:0] CntLast  = CW'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        APPLY,
        RELEASE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AttrWidth-1:0]  attr_q [NumPads];
    logic [AttrWidth-1:0]  shadow_q;
    logic [IW-1:0]         idx_q;
    logic [NumPads-1:0]    lock_q;
    logic                  rvalid_q;
    logic                  err_q, err_d;
    logic [AttrWidth-1:0]  rdata_q, rdata_d;

    logic [IW-1:0]         pad_idx;
    logic [AttrWidth-1:0]  cur;
    logic                  busy;
    logic                  acc;
    logic                  lock_wr;

    assign pad_idx = addr_i[IW-1:0];
    assign cur     = attr_q[pad_idx];
    assign busy    = (state_q != IDLE);
    assign lock_wr = req_i && we_i && (addr_i == LockAddr);

    // Access decode; error priority: range, lock, busy, then no-op write.
    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        acc     = 1'b0;
        if (req_i) begin
            if (addr_i > LockAddr) begin
                err_d = 1'b1;
            end else if (addr_i == LockAddr) begin
                if (!we_i) rdata_d[NumPads-1:0] = lock_q;
            end else if (!we_i) begin
                rdata_d = cur;
            end else if (lock_q[pad_idx] || busy) begin
                err_d = 1'b1;
            end else if (wdata_i != cur) begin
                acc = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = GATE;
                    cnt_d   = '0;
                end
            end
            GATE: begin
                if (cnt_q == CntLast) state_d = APPLY;
                else cnt_d = cnt_q + 1'b1;
            end
            APPLY: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                if (cnt_q == CntLast) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            lock_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < NumPads; i++) attr_q[i] <= PadTypeDefault;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= req_i;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            if (acc) begin
                shadow_q <= wdata_i;
                idx_q    <= pad_idx;
            end
            if (lock_wr) lock_q <= lock_q | wdata_i[NumPads-1:0];
            if (state_q == APPLY) attr_q[idx_q] <= shadow_q;
        end
    end

    always_comb begin
        pad_gate_o = '1;
        if (busy) pad_gate_o[idx_q] = 1'b0;
    end

    for (genvar g = 0; g < NumPads; g++) begin : g_attr
        assign attr_o[g*AttrWidth +: AttrWidth] = attr_q[g];
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = busy;

endmodule
